// File: rtl/puck_mover.sv
// puck_mover: moves a 4x4 puck around a playfield, one pixel diagonally per step.
// On each step the old puck is erased (16 background pixels), the position is
// updated with saturation at the field edges, and the puck is redrawn (16 pixels).
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     synchronous active-low reset
//   enable      lets the step timer run
//   horizontal  1 = move right, 0 = move left (sampled in MOVE only)
//   vertical    1 = move up,    0 = move down (sampled in MOVE only)
//   x, y        registered puck top-left position
//   plot_x/y    pixel coordinate for the frame-buffer writer
//   colour      pixel colour for the frame-buffer writer
//   plot        write strobe, one pixel per cycle while high
//   busy        high whenever a step is in progress
//   step_done   one-cycle pulse at the end of each step
module puck_mover #(
  parameter int unsigned FIELD_W  = 100,
  parameter int unsigned FIELD_H  = 100,
  parameter int unsigned BOX      = 4,
  parameter int unsigned TICK_DIV = 833333,
  parameter int unsigned START_X  = 48,
  parameter int unsigned START_Y  = 48,
  parameter logic [2:0]  BG_COL   = 3'b000,
  parameter logic [2:0]  PUCK_COL = 3'b111
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       horizontal,
  input  logic       vertical,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       step_done
);

  localparam int unsigned CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);
  localparam logic [7:0] XMax   = 8'(FIELD_W - BOX);
  localparam logic [6:0] YMax   = 7'(FIELD_H - BOX);
  localparam logic [7:0] XStart = 8'(START_X);
  localparam logic [6:0] YStart = 7'(START_Y);

  typedef enum logic [2:0] {StIdle, StErase, StMove, StDraw, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [7:0]      plot_x_q, plot_x_d;
  logic [6:0]      plot_y_q, plot_y_d;
  logic [2:0]      colour_q, colour_d;
  logic            plot_q, plot_d;
  logic            done_q, done_d;
  logic            tick;

  // Step timer keeps running during a step; ticks seen while busy are dropped.
  always_comb begin
    tick  = enable && (cnt_q == CntMax);
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StErase;
          idx_d   = 4'd0;
        end
      end
      StErase: begin
        if (idx_q == 4'd15) state_d = StMove;
        else                idx_d   = idx_q + 4'd1;
      end
      StMove: begin
        state_d = StDraw;
        idx_d   = 4'd0;
        if (horizontal) x_d = (x_q >= XMax) ? XMax : x_q + 8'd1;
        else            x_d = (x_q == 8'd0) ? 8'd0 : x_q - 8'd1;
        if (vertical)   y_d = (y_q == 7'd0) ? 7'd0 : y_q - 7'd1;
        else            y_d = (y_q >= YMax) ? YMax : y_q + 7'd1;
      end
      StDraw: begin
        if (idx_q == 4'd15) state_d = StDone;
        else                idx_d   = idx_q + 4'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pixel outputs are registered from the next state so they line up with the
  // state they belong to; DRAW uses x_d/y_d so the first pixel sees the new position.
  always_comb begin
    plot_d   = 1'b0;
    done_d   = (state_d == StDone);
    plot_x_d = plot_x_q;
    plot_y_d = plot_y_q;
    colour_d = colour_q;
    if (state_d == StErase || state_d == StDraw) begin
      plot_d   = 1'b1;
      plot_x_d = x_d + {6'd0, idx_d[1:0]};
      plot_y_d = y_d + {5'd0, idx_d[3:2]};
      colour_d = (state_d == StDraw) ? PUCK_COL : BG_COL;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= 4'd0;
      x_q      <= XStart;
      y_q      <= YStart;
      plot_x_q <= 8'd0;
      plot_y_q <= 7'd0;
      colour_q <= BG_COL;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      plot_x_q <= plot_x_d;
      plot_y_q <= plot_y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign plot_x    = plot_x_q;
  assign plot_y    = plot_y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign step_done = done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_puck_mover.sv
// Directed bench for puck_mover with a 4-cycle step timer.
module tb_puck_mover;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       horizontal = 1'b1;
  logic       vertical = 1'b0;
  logic [7:0] x, plot_x;
  logic [6:0] y, plot_y;
  logic [2:0] colour;
  logic       plot, busy, step_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mx;
  logic [6:0] my;

  puck_mover #(
    .TICK_DIV(4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .horizontal(horizontal),
    .vertical  (vertical),
    .x         (x),
    .y         (y),
    .plot_x    (plot_x),
    .plot_y    (plot_y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .step_done (step_done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Leaves the bench at a negedge with reset just released.
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_x", x, 48);
    check("rst_y", y, 48);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", step_done, 0);
    check("rst_plot_x", plot_x, 0);
    check("rst_plot_y", plot_y, 0);
    check("rst_colour", colour, 0);
    reset_n = 1'b1;
  endtask

  task automatic wait_plot(input int budget, output int n);
    n = 0;
    while (!plot && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!plot) check("plot_timeout", 0, 1);
  endtask

  // Entered at the negedge showing the first erase pixel.
  task automatic check_step(input int ex0, input int ey0, input bit toggle_h, input bit fh,
                            input int abort_at);
    int hv, ex1, ey1, got_plot;
    hv  = toggle_h ? int'(fh) : int'(horizontal);
    ex1 = (hv != 0) ? ((ex0 >= 96) ? 96 : ex0 + 1) : ((ex0 == 0) ? 0 : ex0 - 1);
    ey1 = vertical ? ((ey0 == 0) ? 0 : ey0 - 1) : ((ey0 >= 96) ? 96 : ey0 + 1);
    for (int i = 0; i < 16; i++) begin
      check("erase_plot", plot, 1);
      check("erase_px", plot_x, ex0 + i % 4);
      check("erase_py", plot_y, ey0 + i / 4);
      check("erase_col", colour, 0);
      check("erase_x", x, ex0);
      check("erase_busy", busy, 1);
      if (toggle_h) horizontal = (i == 15) ? fh : i[0];
      @(negedge clock);
    end
    check("move_plot", plot, 0);
    check("move_x", x, ex0);
    check("move_y", y, ey0);
    check("move_busy", busy, 1);
    @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      if (i == abort_at) begin
        reset_n = 1'b0;
        @(negedge clock);
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        check("abort_x", x, 48);
        check("abort_y", y, 48);
        check("abort_px", plot_x, 0);
        check("abort_done", step_done, 0);
        enable  = 1'b0;
        reset_n = 1'b1;
        got_plot = 0;
        repeat (20) begin
          @(negedge clock);
          if (plot || busy) got_plot++;
        end
        check("abort_no_draw", got_plot, 0);
        return;
      end
      check("draw_plot", plot, 1);
      check("draw_px", plot_x, ex1 + i % 4);
      check("draw_py", plot_y, ey1 + i / 4);
      check("draw_col", colour, 7);
      check("draw_x", x, ex1);
      check("draw_y", y, ey1);
      @(negedge clock);
    end
    check("done_pulse", step_done, 1);
    check("done_plot", plot, 0);
    check("done_busy", busy, 1);
    @(negedge clock);
    check("idle_done", step_done, 0);
    check("idle_busy", busy, 0);
    mx = 8'(ex1);
    my = 7'(ey1);
  endtask

  initial begin
    int n, quiet;
    // Scenario 1: basic step right/down from the start position.
    horizontal = 1'b1;
    vertical   = 1'b0;
    enable     = 1'b1;
    do_reset();
    wait_plot(20, n);
    check("s1_latency", n, 4);
    check_step(48, 48, 0, 0, -1);
    check("s1_x", x, 49);
    check("s1_y", y, 49);

    // Scenario 2: run into the right and bottom edges.
    for (int k = 0; k < 49; k++) begin
      wait_plot(20, n);
      check_step(mx, my, 0, 0, -1);
    end
    check("s2_x_sat", x, 96);
    check("s2_y_sat", y, 96);

    // Scenario 3: run into the left and top edges, then bounce down.
    horizontal = 1'b0;
    vertical   = 1'b1;
    for (int k = 0; k < 97; k++) begin
      wait_plot(20, n);
      check_step(mx, my, 0, 0, -1);
    end
    check("s3_y_zero", y, 0);
    check("s3_x_zero", x, 0);
    vertical   = 1'b0;
    horizontal = 1'b1;
    wait_plot(20, n);
    check_step(mx, my, 0, 0, -1);
    check("s3_y_one", y, 1);
    check("s3_x_one", x, 1);

    // Scenario 4: pause the timer at count 2.
    enable = 1'b1;
    do_reset();
    repeat (2) @(negedge clock);
    enable = 1'b0;
    quiet = 0;
    repeat (10) begin
      @(negedge clock);
      if (plot || busy) quiet++;
    end
    check("s4_no_plot", quiet, 0);
    enable = 1'b1;
    wait_plot(20, n);
    check("s4_resume", n, 2);
    check_step(48, 48, 0, 0, -1);

    // Scenario 5: reset in the middle of DRAW.
    wait_plot(20, n);
    check_step(49, 49, 0, 0, 7);

    // Scenario 6: horizontal only matters in the MOVE cycle.
    enable = 1'b1;
    do_reset();
    wait_plot(20, n);
    check_step(48, 48, 1, 0, -1);
    check("s6_left", x, 47);
    wait_plot(20, n);
    check_step(47, 49, 1, 1, -1);
    check("s6_right", x, 48);
    check("s6_y", y, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/puck_mover.md
PUCK_MOVER -- requirements
Module: puck_mover

Interface
REQ-001 Parameter FIELD_W, default 100, playfield width in pixels.
REQ-002 Parameter FIELD_H, default 100, playfield height in pixels.
REQ-003 Parameter BOX, default 4, puck edge length in pixels; fixed at 4 for this block.
REQ-004 Parameter TICK_DIV, default 833333, clock cycles per movement step.
REQ-005 Parameter START_X, default 48, and START_Y, default 48, puck top-left after reset.
REQ-006 Parameters BG_COL, default 3'b000, and PUCK_COL, default 3'b111, erase and draw colours.
REQ-007 clock  input  1  system clock; all logic on its rising edge.
REQ-008 reset_n  input  1  synchronous, active-low reset.
REQ-009 enable  input  1  high lets the step timer run.
REQ-010 horizontal  input  1  direction flag; 1 = +x (right), 0 = -x (left).
REQ-011 vertical  input  1  direction flag; 1 = -y (up), 0 = +y (down).
REQ-012 x  output  8  puck top-left column, registered.
REQ-013 y  output  7  puck top-left row, registered.
REQ-014 plot_x  output  8  pixel column to the frame-buffer writer.
REQ-015 plot_y  output  7  pixel row to the frame-buffer writer.
REQ-016 colour  output  3  pixel colour to the frame-buffer writer.
REQ-017 plot  output  1  write strobe; the pixel is written on every cycle plot is high.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 step_done  output  1  one-cycle pulse at the end of each step.

Function
REQ-020 Step timer shall count 0..TICK_DIV-1 while enable is high, wrap to 0, and raise internal tick for the single cycle at count TICK_DIV-1.
REQ-021 While enable is low, the step timer shall hold its value and tick shall stay low.
REQ-022 FSM states: IDLE, ERASE, MOVE, DRAW, DONE.
REQ-023 IDLE -> ERASE on tick; otherwise remain in IDLE.
REQ-024 ERASE shall last exactly 16 cycles with plot=1, colour=BG_COL, and plot_x=x+(i mod 4), plot_y=y+(i div 4) for pixel index i=0..15, in raster order.
REQ-025 MOVE shall last 1 cycle with plot=0 and shall sample horizontal and vertical in that cycle only.
REQ-026 MOVE: x_next=x+1 if horizontal=1, else x-1; y_next=y-1 if vertical=1, else y+1.
REQ-027 Clamping: x shall saturate to [0, FIELD_W-BOX] and y to [0, FIELD_H-BOX]; x never wraps below 0 or above 96, and y likewise for defaults.
REQ-028 DRAW shall last 16 cycles in the same raster order as ERASE, using the updated x,y with colour=PUCK_COL and plot=1.
REQ-029 DONE shall last 1 cycle with step_done=1 and plot=0, then return to IDLE.
REQ-030 A step therefore occupies 34 cycles, from ERASE entry to DONE exit.
REQ-031 A tick arriving while busy=1 shall be dropped, not queued.
REQ-032 If enable falls mid-step, the current step shall complete normally.
REQ-033 x and y shall change only on the MOVE-to-DRAW transition.
REQ-034 In IDLE, MOVE and DONE, plot shall be 0 and plot_x, plot_y, colour shall hold their last values.
REQ-035 Pixel coordinate sums shall be computed at output width; the clamp guarantees they never exceed the field.

Reset
REQ-036 When reset_n=0 at a rising edge, the following shall take effect on that edge, overriding all other activity including a mid-step state: x=START_X, y=START_Y, FSM=IDLE, step timer=0, pixel index=0, plot=0, step_done=0, busy=0, plot_x=0, plot_y=0, colour=BG_COL.

Verification
REQ-037 Bench condition: TICK_DIV=4 for all scenarios.
REQ-038 Scenario 1: reset, enable=1, horizontal=1, vertical=0 -> first plot pulse 4 cycles after reset release; 16 erase pixels (48..51,48..51) in BG_COL; then x=49, y=49; then 16 draw pixels (49..52,49..52) in PUCK_COL; step_done 34 cycles after ERASE entry.
REQ-039 Scenario 2: force x=96 via repeated steps with horizontal=1 -> x stays 96 and never reaches 97.
REQ-040 Scenario 3: drive the puck to y=0 with vertical=1, then one more step -> y remains 0; set vertical=0 -> next step y=1.
REQ-041 Scenario 4: enable=0 after 2 timer counts, hold 10 cycles, then enable=1 -> tick occurs 2 cycles later; no plot while enable is low in IDLE.
REQ-042 Scenario 5: assert reset_n=0 during DRAW pixel 7 -> next cycle plot=0, busy=0, x=48, y=48; no further draw pixels.
REQ-043 Scenario 6: toggle horizontal during ERASE, then hold it stable from MOVE onward -> the update uses the value present in the MOVE cycle only.
